// File: rtl/pc_seq_pkg.sv
// Shared types, default vectors and target-address helpers for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  // J-type target: region bits from the delay-slot address, word index below.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  // Branch target: sign-extended word offset added to pc+4, wrapping at 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] off);
    logic [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return pc_plus4 + disp;
  endfunction

endpackage

// File: rtl/pc_seq_target_calc.sv
// Combinational next-PC selection and misaligned-JR detection.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        i_advance,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_offset,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_next_pc,
  output logic        o_addr_err
);

  logic w_jr_misaligned;

  assign w_jr_misaligned = (i_jr_target[1:0] != 2'b00);

  // Priority mux: JR (trapping if misaligned) > J > taken branch > sequential.
  always_comb begin
    o_next_pc  = i_pc;
    o_addr_err = 1'b0;
    if (i_advance) begin
      if (i_jr) begin
        if (w_jr_misaligned) begin
          o_next_pc  = EXC_VECTOR;
          o_addr_err = 1'b1;
        end else begin
          o_next_pc = i_jr_target;
        end
      end else if (i_jump) begin
        o_next_pc = jump_target(i_pc_plus4, i_jump_index);
      end else if (i_branch_taken) begin
        o_next_pc = branch_target(i_pc_plus4, i_branch_offset);
      end else begin
        o_next_pc = i_pc_plus4;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer: fetches one word per
// cycle, parks a fetched word while decode stalls, and redirects on jumps,
// branches, JR and exceptions.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic        addr_err
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_buf;

  logic        w_in_fetch;
  logic        w_in_hold;
  logic        w_advance;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_addr_err;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_hold  = (r_state == ST_HOLD);
  assign w_pc_plus4 = r_pc + 32'd4;

  // An exception kills whatever instruction would be presented this cycle.
  assign instr_valid = !exception &&
                       ((w_in_fetch && imem_ack && !stall) || w_in_hold);
  assign w_advance   = instr_valid && !stall;

  assign imem_req  = w_in_fetch;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = w_in_hold  ? r_instr_buf :
                     w_in_fetch ? imem_rdata  : 32'h0;
  assign addr_err  = w_addr_err;

  pc_target_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_calc (
    .i_advance       (w_advance),
    .i_pc            (r_pc),
    .i_pc_plus4      (w_pc_plus4),
    .i_jump          (jump),
    .i_jump_index    (jump_index),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jr            (jr),
    .i_jr_target     (jr_target),
    .o_next_pc       (w_next_pc),
    .o_addr_err      (w_addr_err)
  );

  // Fetch FSM, PC register and stall buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_instr_buf <= 32'h0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (exception) begin
            r_pc <= EXC_VECTOR;
          end else if (imem_ack) begin
            if (stall) begin
              r_instr_buf <= imem_rdata;
              r_state     <= ST_HOLD;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        ST_HOLD: begin
          if (exception) begin
            r_pc    <= EXC_VECTOR;
            r_state <= ST_FETCH;
          end else if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule
